// File: rtl/axi_mem_responder_if.sv
// AXI4 channel bundle between the crossbar master port and the memory responder.
// Signal names keep the responder-side _i/_o suffixes so both ends read alike.
interface axi_mem_responder_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 11,
  parameter int AXI_USER_WIDTH = 1
);
  logic [AXI_ID_WIDTH-1:0]     aw_id_i;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i;
  logic [7:0]                  aw_len_i;
  logic [2:0]                  aw_size_i;
  logic [1:0]                  aw_burst_i;
  logic [AXI_USER_WIDTH-1:0]   aw_user_i;
  logic                        aw_valid_i, aw_ready_o;

  logic [AXI_DATA_WIDTH-1:0]   w_data_i;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i;
  logic                        w_last_i, w_valid_i, w_ready_o;

  logic [AXI_ID_WIDTH-1:0]     b_id_o;
  logic [1:0]                  b_resp_o;
  logic                        b_valid_o, b_ready_i;

  logic [AXI_ID_WIDTH-1:0]     ar_id_i;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_i;
  logic [7:0]                  ar_len_i;
  logic [2:0]                  ar_size_i;
  logic [1:0]                  ar_burst_i;
  logic [AXI_USER_WIDTH-1:0]   ar_user_i;
  logic                        ar_valid_i, ar_ready_o;

  logic [AXI_ID_WIDTH-1:0]     r_id_o;
  logic [AXI_DATA_WIDTH-1:0]   r_data_o;
  logic [1:0]                  r_resp_o;
  logic                        r_last_o;
  logic [AXI_USER_WIDTH-1:0]   r_user_o;
  logic                        r_valid_o, r_ready_i;

  modport slave (
    input  aw_id_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i, aw_user_i, aw_valid_i,
    output aw_ready_o,
    input  w_data_i, w_strb_i, w_last_i, w_valid_i,
    output w_ready_o,
    output b_id_o, b_resp_o, b_valid_o,
    input  b_ready_i,
    input  ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_user_i, ar_valid_i,
    output ar_ready_o,
    output r_id_o, r_data_o, r_resp_o, r_last_o, r_user_o, r_valid_o,
    input  r_ready_i
  );

  modport master (
    output aw_id_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i, aw_user_i, aw_valid_i,
    input  aw_ready_o,
    output w_data_i, w_strb_i, w_last_i, w_valid_i,
    input  w_ready_o,
    input  b_id_o, b_resp_o, b_valid_o,
    output b_ready_i,
    output ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_user_i, ar_valid_i,
    input  ar_ready_o,
    input  r_id_o, r_data_o, r_resp_o, r_last_o, r_user_o, r_valid_o,
    output r_ready_i
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave endpoint serving one FIXED/INCR burst at a time into a single-port
// SRAM with one-cycle read latency; round-robin between AW and AR when both wait.
module axi_mem_responder #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 11,
  parameter int AXI_USER_WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  axi_mem_responder_if.slave          axi,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [AXI_ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [AXI_DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0] mem_be_o,
  input  logic [AXI_DATA_WIDTH-1:0]   mem_rdata_i
);
  localparam int                        OFF       = $clog2(AXI_DATA_WIDTH/8);
  localparam logic [2:0]                MAX_SIZE  = 3'(OFF);
  localparam logic [AXI_ADDR_WIDTH-1:0] LOW_MASK  = AXI_ADDR_WIDTH'((1 << OFF) - 1);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_REQ, RD_DATA} state_t;

  state_t                      state;
  logic [AXI_ID_WIDTH-1:0]     id;
  logic [AXI_ADDR_WIDTH-1:0]   addr, nxt_addr, step;
  logic [7:0]                  len, cnt;
  logic [2:0]                  size;
  logic [1:0]                  burst;
  logic                        err, last_rd, rd_first;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q, rd_word;
  logic                        aw_sel, ar_sel, aw_hs, ar_hs, beat_last, wr_go;
  logic                        unused_ok;

  function automatic logic bad_req(input logic [2:0] s, input logic [1:0] b);
    return (s > MAX_SIZE) || b[1];
  endfunction

  // last_rd resets high so a simultaneous AW/AR after reset goes to the write side
  assign aw_sel    = axi.aw_valid_i && (!axi.ar_valid_i || last_rd);
  assign ar_sel    = axi.ar_valid_i && !aw_sel;
  assign aw_hs     = (state == IDLE) && !rst && aw_sel;
  assign ar_hs     = (state == IDLE) && !rst && ar_sel;
  assign beat_last = (cnt == len);
  assign step      = {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1} << size;
  assign nxt_addr  = (burst == 2'b01) ? addr + step : addr;
  assign rd_word   = err ? '0 : mem_rdata_i;
  assign wr_go     = (state == WR) && axi.w_valid_i && !err;

  assign axi.aw_ready_o = aw_hs;
  assign axi.ar_ready_o = ar_hs;
  assign axi.w_ready_o  = (state == WR);
  assign axi.b_valid_o  = (state == WR_RESP);
  assign axi.b_id_o     = id;
  assign axi.b_resp_o   = {err, 1'b0};
  assign axi.r_valid_o  = (state == RD_DATA);
  assign axi.r_id_o     = id;
  assign axi.r_resp_o   = {err, 1'b0};
  assign axi.r_last_o   = (state == RD_DATA) && beat_last;
  assign axi.r_user_o   = '0;
  // memory data is only live in the first RD_DATA cycle; afterwards replay the capture
  assign axi.r_data_o   = rd_first ? rd_word : rdata_q;

  assign mem_req_o   = wr_go || ((state == RD_REQ) && !err);
  assign mem_we_o    = wr_go;
  assign mem_addr_o  = addr & ~LOW_MASK;
  assign mem_wdata_o = axi.w_data_i;
  assign mem_be_o    = axi.w_strb_i;

  assign unused_ok = ^{axi.aw_user_i, axi.ar_user_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      id       <= '0;
      addr     <= '0;
      len      <= '0;
      size     <= '0;
      burst    <= '0;
      cnt      <= '0;
      err      <= 1'b0;
      last_rd  <= 1'b1;
      rd_first <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            id <= axi.aw_id_i; addr <= axi.aw_addr_i; len <= axi.aw_len_i;
            size <= axi.aw_size_i; burst <= axi.aw_burst_i; cnt <= '0;
            err <= bad_req(axi.aw_size_i, axi.aw_burst_i);
            last_rd <= 1'b0;
            state <= WR;
          end else if (ar_hs) begin
            id <= axi.ar_id_i; addr <= axi.ar_addr_i; len <= axi.ar_len_i;
            size <= axi.ar_size_i; burst <= axi.ar_burst_i; cnt <= '0;
            err <= bad_req(axi.ar_size_i, axi.ar_burst_i);
            last_rd <= 1'b1;
            state <= RD_REQ;
          end
        end
        WR: begin
          if (axi.w_valid_i) begin
            // burst length is trusted from len; a misplaced w_last only flags the response
            if (axi.w_last_i != beat_last) err <= 1'b1;
            addr <= nxt_addr;
            cnt  <= cnt + 8'd1;
            if (beat_last) state <= WR_RESP;
          end
        end
        WR_RESP: if (axi.b_ready_i) state <= IDLE;
        RD_REQ: begin
          rd_first <= 1'b1;
          state    <= RD_DATA;
        end
        RD_DATA: begin
          rd_first <= 1'b0;
          if (rd_first) rdata_q <= rd_word;
          if (axi.r_ready_i) begin
            if (beat_last) state <= IDLE;
            else begin
              addr  <= nxt_addr;
              cnt   <= cnt + 8'd1;
              state <= RD_REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized bench for axi_mem_responder: SRAM model on the memory port plus a
// word-array reference that predicts every memory access and response beat.
module tb_axi_mem_responder;
  localparam int AW = 32, DW = 32, IW = 11, UW = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_mem_responder_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
                         .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)) bus ();

  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_rdata = '0;

  axi_mem_responder #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
                      .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)) dut (
    .clk(clk), .rst(rst), .axi(bus.slave),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
  );

  logic [31:0] sram    [0:1023];
  logic [31:0] ref_mem [0:1023];
  int n_vec = 0, n_err = 0, n_memreq = 0;

  always @(posedge clk) begin
    if (mem_req) begin
      n_memreq <= n_memreq + 1;
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else mem_rdata <= sram[mem_addr[11:2]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                             input logic [2:0] sz, input logic [1:0] bu);
    if (bu == 2'b00) return a;
    return a + 32'(i) * (32'd1 << sz);
  endfunction

  // bad_last >= 0 puts w_last on that beat only; rst_beat >= 0 resets during that beat
  task automatic do_write(input logic [10:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu, input bit both,
                          input int bad_last, input int rst_beat);
    bit          err;
    bit          last;
    int          to;
    logic [31:0] ba, d;
    logic [3:0]  s;
    err = (sz > 3'd2) || bu[1];
    @(negedge clk);
    bus.aw_id_i = id; bus.aw_addr_i = a; bus.aw_len_i = len;
    bus.aw_size_i = sz; bus.aw_burst_i = bu; bus.aw_valid_i = 1'b1;
    if (both) bus.ar_valid_i = 1'b1;
    #1; to = 0;
    while (!bus.aw_ready_o && to < 16) begin @(negedge clk); #1; to++; end
    check("aw_ready", bus.aw_ready_o, 1);
    if (both) check("arb_ar_ready", bus.ar_ready_o, 0);
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk);
      bus.aw_valid_i = 1'b0;
      if (both) bus.ar_valid_i = 1'b0;
      d = $urandom; s = 4'($urandom_range(0, 15));
      last = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
      bus.w_valid_i = 1'b1; bus.w_data_i = d; bus.w_strb_i = s; bus.w_last_i = last;
      #1;
      check("w_ready", bus.w_ready_o, 1);
      check("wr_req", mem_req, !err);
      ba = beat_addr(a, i, sz, bu);
      if (!err) begin
        check("wr_we", mem_we, 1);
        check("wr_addr", mem_addr, ba & ~32'h3);
        check("wr_be", mem_be, s);
      end
      if (i == rst_beat) begin
        rst = 1'b1; #1;
        check("rst_aw_ready", bus.aw_ready_o, 0);
        check("rst_w_ready", bus.w_ready_o, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_valids", {bus.b_valid_o, bus.r_valid_o}, 0);
        @(negedge clk); bus.w_valid_i = 1'b0;
        @(negedge clk); rst = 1'b0;
        return;
      end
      if (!err)
        for (int b = 0; b < 4; b++) if (s[b]) ref_mem[ba[11:2]][8*b +: 8] = d[8*b +: 8];
      if (last != (i == int'(len))) err = 1'b1;
    end
    @(negedge clk);
    bus.w_valid_i = 1'b0; bus.w_last_i = 1'b0; bus.b_ready_i = 1'b0;
    #1; to = 0;
    while (!bus.b_valid_o && to < 16) begin @(negedge clk); #1; to++; end
    check("b_valid", bus.b_valid_o, 1);
    check("b_id", bus.b_id_o, id);
    check("b_resp", bus.b_resp_o, err ? 2'b10 : 2'b00);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk); #1;
      check("b_hold", {bus.b_valid_o, bus.b_resp_o}, {1'b1, err ? 2'b10 : 2'b00});
    end
    bus.b_ready_i = 1'b1;
    @(negedge clk); bus.b_ready_i = 1'b0;
  endtask

  task automatic do_read(input logic [10:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu, input bit both,
                         input int stall_beat, input int stall_cyc);
    bit          err;
    int          to;
    logic [31:0] ba, exp_d;
    err = (sz > 3'd2) || bu[1];
    @(negedge clk);
    bus.ar_id_i = id; bus.ar_addr_i = a; bus.ar_len_i = len;
    bus.ar_size_i = sz; bus.ar_burst_i = bu; bus.ar_valid_i = 1'b1; bus.r_ready_i = 1'b0;
    if (both) bus.aw_valid_i = 1'b1;
    #1; to = 0;
    while (!bus.ar_ready_o && to < 16) begin @(negedge clk); #1; to++; end
    check("ar_ready", bus.ar_ready_o, 1);
    if (both) check("arb_aw_ready", bus.aw_ready_o, 0);
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk);
      bus.ar_valid_i = 1'b0; bus.r_ready_i = 1'b0;
      if (both) bus.aw_valid_i = 1'b0;
      #1;
      ba = beat_addr(a, i, sz, bu);
      check("rd_req", mem_req, !err);
      check("rd_valid_early", bus.r_valid_o, 0);
      if (!err) check("rd_addr", {mem_we, mem_addr}, {1'b0, ba & ~32'h3});
      @(negedge clk); #1;
      exp_d = err ? 32'h0 : ref_mem[ba[11:2]];
      check("r_valid", bus.r_valid_o, 1);
      check("r_data", bus.r_data_o, exp_d);
      check("r_meta", {bus.r_id_o, bus.r_resp_o, bus.r_last_o, bus.r_user_o},
            {id, err ? 2'b10 : 2'b00, i == int'(len), 1'b0});
      if (i == stall_beat)
        repeat (stall_cyc) begin
          @(negedge clk); #1;
          check("r_stall", {mem_req, bus.r_valid_o, bus.r_data_o}, {1'b0, 1'b1, exp_d});
        end
      bus.r_ready_i = 1'b1;
    end
    @(negedge clk); bus.r_ready_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int base, l;
    for (int k = 0; k < 1024; k++) begin sram[k] = '0; ref_mem[k] = '0; end
    rst = 1'b1;
    bus.aw_id_i = '0; bus.aw_addr_i = '0; bus.aw_len_i = '0; bus.aw_size_i = '0;
    bus.aw_burst_i = '0; bus.aw_user_i = '0; bus.aw_valid_i = 1'b0;
    bus.w_data_i = '0; bus.w_strb_i = '0; bus.w_last_i = 1'b0; bus.w_valid_i = 1'b0;
    bus.b_ready_i = 1'b0;
    bus.ar_id_i = '0; bus.ar_addr_i = '0; bus.ar_len_i = '0; bus.ar_size_i = '0;
    bus.ar_burst_i = '0; bus.ar_user_i = '0; bus.ar_valid_i = 1'b0; bus.r_ready_i = 1'b0;

    // reset state, with both address channels requesting
    @(negedge clk);
    bus.aw_valid_i = 1'b1; bus.ar_valid_i = 1'b1;
    #1;
    check("rst_readys", {bus.aw_ready_o, bus.ar_ready_o, bus.w_ready_o}, 0);
    check("rst_valids", {bus.b_valid_o, bus.r_valid_o}, 0);
    check("rst_mem", {mem_req, mem_we}, 0);
    check("rst_resp_last", {bus.b_resp_o, bus.r_last_o}, 0);
    bus.aw_valid_i = 1'b0; bus.ar_valid_i = 1'b0;
    @(negedge clk); rst = 1'b0;

    // simultaneous AW/AR: write first out of reset, then read, then write again
    do_write(11'h12, 32'h100, 8'd3, 3'd2, 2'b01, 1'b1, -1, -1);
    do_read (11'h34, 32'h100, 8'd3, 3'd2, 2'b01, 1'b1, -1, 0);
    do_write(11'h56, 32'h200, 8'd0, 3'd2, 2'b01, 1'b1, -1, -1);

    // WRAP read and early w_last both yield SLVERR
    do_read (11'h7ff, 32'h100, 8'd1, 3'd2, 2'b10, 1'b0, -1, 0);
    do_write(11'h001, 32'h300, 8'd2, 3'd2, 2'b01, 1'b0, 0, -1);
    do_read (11'h002, 32'h300, 8'd2, 3'd2, 2'b01, 1'b0, -1, 0);

    // stalled read mid-burst
    do_read (11'h0aa, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0, 1, 5);

    // FIXED len 255: 256 accesses to one word
    base = n_memreq;
    do_write(11'h0f0, 32'h404, 8'd255, 3'd2, 2'b00, 1'b0, -1, -1);
    check("fixed_count", 64'(n_memreq - base), 256);
    do_read (11'h0f1, 32'h404, 8'd3, 3'd2, 2'b00, 1'b0, 2, 3);

    // reset during write beat 2, then normal service resumes
    do_write(11'h0c0, 32'h500, 8'd5, 3'd2, 2'b01, 1'b0, -1, 2);
    do_write(11'h0c1, 32'h500, 8'd1, 3'd2, 2'b01, 1'b0, -1, -1);
    do_read (11'h0c2, 32'h500, 8'd3, 3'd2, 2'b01, 1'b0, -1, 0);

    // randomized mix
    for (int t = 0; t < 40; t++) begin
      logic [10:0] rid;
      logic [31:0] ra;
      logic [2:0]  rs;
      logic [1:0]  rb;
      rid = 11'($urandom);
      ra  = 32'($urandom_range(0, 'h7ff));
      l   = $urandom_range(0, 7);
      rs  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      rb  = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        do_write(rid, ra, 8'(l), rs, rb, 1'b0,
                 ($urandom_range(0, 5) == 0) ? $urandom_range(0, l) : -1, -1);
      else
        do_read(rid, ra, 8'(l), rs, rb, 1'b0, $urandom_range(0, l), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
